master_spi_tx: RTL and testbench
================================

MASTER_SPI_TX -- requirements
Module: master_spi_tx

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the clock-divider setting.
REQ-002 SHALL have parameter TAIL_EDGES, default 4, number of msck rising edges with msen low after each frame.
REQ-003 SHALL have port sclk  input  1  system clock; all logic on posedge sclk.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port empty_i  input  1  TX FIFO empty flag.
REQ-006 SHALL have port fifo_rd_o  output  1  one-sclk TX FIFO read pulse.
REQ-007 SHALL have port tx_data_i  input  8  FIFO read data, valid the sclk cycle after fifo_rd_o.
REQ-008 SHALL have port clk_div_r  input  DIV_W  msck half-period minus one, in sclk cycles.
REQ-009 SHALL have port msck  output  1  serial clock, registered.
REQ-010 SHALL have port msci  output  1  serial data, MSB first, registered.
REQ-011 SHALL have port msen  output  1  frame enable, active-high, registered.
REQ-012 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL run msck free-running from reset release; high and low phases each last exactly clk_div_r+1 sclk cycles.
REQ-014 SHALL latch clk_div_r only in IDLE; changes during a frame SHALL take effect after return to IDLE.
REQ-015 SHALL change msci and msen only in the sclk cycle where msck goes 1->0 (fall strobe), so they are stable at every msck rising edge.
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, TAIL.
REQ-017 IDLE: when empty_i=0, SHALL pulse fifo_rd_o for one cycle and go to LOAD; otherwise hold msen=0, msci=0.
REQ-018 LOAD: SHALL capture tx_data_i into the shift register one cycle after the read pulse. At the next fall strobe it SHALL set msen=1 and msci=bit7, set the bit counter to 0, and go to SHIFT.
REQ-019 SHIFT: at each fall strobe, SHALL increment the bit counter (3 bits) and drive the next lower bit on msci.
REQ-020 SHALL prefetch: at the fall strobe that launches bit0, if empty_i=0, SHALL pulse fifo_rd_o once and store the byte in a next-byte buffer with valid flag.
REQ-021 At the fall strobe ending bit0, if the buffer is valid, SHALL load it, drive its bit7, keep msen=1 with no gap, clear valid, and stay in SHIFT.
REQ-022 At the fall strobe ending bit0, if the buffer is not valid, SHALL set msen=0 and msci=0 and go to TAIL.
REQ-023 TAIL: SHALL count TAIL_EDGES msck rising edges, then go to IDLE. A new frame SHALL NOT start before then, even if empty_i=0.
REQ-024 SHALL never assert fifo_rd_o while empty_i=1, and SHALL never issue a second read while a fetched byte is unconsumed.
REQ-025 If empty_i rises after the prefetch point, SHALL finish the current byte and end the frame normally.
REQ-026 With clk_div_r=0 (msck = sclk/2), back-to-back bytes SHALL still stream without a gap.

Reset
REQ-027 On rstn=0, SHALL immediately clear msck, msci, msen, fifo_rd_o and busy_o to 0, set state to IDLE, and clear the counters and buffer valid flag, including mid-frame.
REQ-028 After reset release, the first msck rising edge SHALL occur clk_div_r+1 sclk cycles later.

Structure
REQ-029 Package spi_pkg SHALL hold the state enumeration, the TAIL_EDGES default and the byte width constant (8).
REQ-030 Sub-module spi_clk_gen SHALL produce msck plus one-cycle rise and fall strobes from clk_div_r.
REQ-031 Implementation SHALL be 120-400 lines of RTL excluding the package.

Verification
REQ-032 clk_div_r=1, FIFO holds 0xA5 -> one read pulse; msen high for exactly 8 msck rising edges; msci bits 1,0,1,0,0,1,0,1; a slave_spi_tx checker outputs rx_data_o=0xA5 with one fifo_wr_o pulse.
REQ-033 clk_div_r=0, FIFO holds 0x3C,0xFF,0x00 -> msen high continuously for 24 rising edges; three read pulses; checker receives 0x3C,0xFF,0x00 in order.
REQ-034 Two single-byte writes with the FIFO emptying between them -> msen low for at least 4 rising edges between frames; both bytes are received.
REQ-035 Assert rstn=0 after bit 4 of 0x81 -> all outputs are 0 in the same cycle; after release, busy_o=0 and no read occurs while empty_i=1.
REQ-036 Change clk_div_r from 3 to 0 mid-frame -> half-period stays 4 sclk cycles until IDLE, then becomes 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit master.
package spi_pkg;

    localparam int BYTE_W         = 8;
    localparam int TAIL_EDGES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Free-running serial clock generator with one-cycle rise/fall strobes.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             sclk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] div_i,
    output logic             msck_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             msck_q, msck_d;
    logic             wrap;

    // Strobes mark the sclk cycle whose closing edge flips msck.
    always_comb begin
        wrap   = (cnt_q >= div_i);
        cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
        msck_d = wrap ? ~msck_q : msck_q;
        rise_o = wrap & ~msck_q;
        fall_o = wrap & msck_q;
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            msck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            msck_q <= msck_d;
        end
    end

    assign msck_o = msck_q;

endmodule

// File: rtl/master_spi_tx.sv
// SPI transmit master: pulls bytes from a TX FIFO and streams them MSB first,
// prefetching the next byte so consecutive bytes share one msen frame.
module master_spi_tx
    import spi_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int TAIL_EDGES = TAIL_EDGES_DEF
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              empty_i,
    output logic              fifo_rd_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic [DIV_W-1:0]  clk_div_r,
    output logic              msck,
    output logic              msci,
    output logic              msen,
    output logic              busy_o,
    output state_e            state_o
);

    localparam logic [7:0] TAIL_LAST = 8'(TAIL_EDGES - 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d, div_eff;
    logic [BYTE_W-1:0] sh_q, sh_d, buf_q, buf_d, nb;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        tail_q, tail_d;
    logic              buf_v_q, buf_v_d, have_q, have_d;
    logic              fifo_rd_q, fifo_rd_d, cap_q, cap_d;
    logic              msci_q, msci_d, msen_q, msen_d;
    logic              rise, fall, pf_hit;

    // Divider follows the input only while idle; frames use the latched copy.
    assign div_eff = (state_q == IDLE) ? clk_div_r : div_q;

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .sclk   (sclk),
        .rstn   (rstn),
        .div_i  (div_eff),
        .msck_o (msck),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sh_d      = sh_q;
        buf_d     = buf_q;
        buf_v_d   = buf_v_q;
        have_d    = have_q;
        bit_d     = bit_q;
        tail_d    = tail_q;
        msci_d    = msci_q;
        msen_d    = msen_q;
        fifo_rd_d = 1'b0;
        cap_d     = fifo_rd_q;
        // A prefetched byte can arrive on the very strobe that needs it.
        pf_hit    = cap_q && (state_q == SHIFT);
        nb        = buf_v_q ? buf_q : tx_data_i;

        if (state_q == IDLE) begin
            div_d = clk_div_r;
        end
        if (cap_q && (state_q == LOAD)) begin
            sh_d   = tx_data_i;
            have_d = 1'b1;
        end
        if (pf_hit) begin
            buf_d   = tx_data_i;
            buf_v_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                msen_d = 1'b0;
                msci_d = 1'b0;
                have_d = 1'b0;
                if (!empty_i) begin
                    fifo_rd_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (fall && have_q) begin
                    msen_d  = 1'b1;
                    msci_d  = sh_q[BYTE_W-1];
                    sh_d    = {sh_q[BYTE_W-2:0], 1'b0};
                    bit_d   = 3'd0;
                    have_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (bit_q != 3'd7) begin
                        bit_d  = bit_q + 3'd1;
                        msci_d = sh_q[BYTE_W-1];
                        sh_d   = {sh_q[BYTE_W-2:0], 1'b0};
                        if ((bit_q == 3'd6) && !empty_i && !buf_v_q) begin
                            fifo_rd_d = 1'b1;
                        end
                    end else if (buf_v_q || pf_hit) begin
                        msci_d  = nb[BYTE_W-1];
                        sh_d    = {nb[BYTE_W-2:0], 1'b0};
                        bit_d   = 3'd0;
                        buf_v_d = 1'b0;
                    end else begin
                        msen_d  = 1'b0;
                        msci_d  = 1'b0;
                        tail_d  = 8'd0;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (rise) begin
                    if (tail_q == TAIL_LAST) begin
                        state_d = IDLE;
                    end else begin
                        tail_d = tail_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            div_q     <= '0;
            sh_q      <= '0;
            buf_q     <= '0;
            buf_v_q   <= 1'b0;
            have_q    <= 1'b0;
            bit_q     <= 3'd0;
            tail_q    <= 8'd0;
            msci_q    <= 1'b0;
            msen_q    <= 1'b0;
            fifo_rd_q <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sh_q      <= sh_d;
            buf_q     <= buf_d;
            buf_v_q   <= buf_v_d;
            have_q    <= have_d;
            bit_q     <= bit_d;
            tail_q    <= tail_d;
            msci_q    <= msci_d;
            msen_q    <= msen_d;
            fifo_rd_q <= fifo_rd_d;
            cap_q     <= cap_d;
        end
    end

    assign msci      = msci_q;
    assign msen      = msen_q;
    assign fifo_rd_o = fifo_rd_q;
    assign busy_o    = (state_q != IDLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_master_spi_tx.sv
// Bench for master_spi_tx: FIFO model, behavioural SPI receiver, directed and random frames.
module tb_master_spi_tx;
    import spi_pkg::*;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       empty_i;
    logic       fifo_rd_o;
    logic [7:0] tx_data_i;
    logic [7:0] clk_div_r;
    logic       msck, msci, msen, busy_o;
    state_e     state_o;

    master_spi_tx dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .empty_i   (empty_i),
        .fifo_rd_o (fifo_rd_o),
        .tx_data_i (tx_data_i),
        .clk_div_r (clk_div_r),
        .msck      (msck),
        .msci      (msci),
        .msen      (msen),
        .busy_o    (busy_o),
        .state_o   (state_o)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         runs_q[$];
    int         gaps_q[$];
    int         nreads = 0;
    int         rd_empty_viol = 0;
    int         edge_viol = 0;
    int         rx_bits = 0;
    int         run = 0;
    int         gap = 0;
    logic [7:0] rx_sh = 8'h00;
    logic       p_msck = 1'b0, p_msci = 1'b0, p_msen = 1'b0, p_rstn = 1'b0;
    logic       rd_seen;

    // FIFO model: read pulse seen during a cycle -> data valid in the next cycle only.
    initial begin
        empty_i   = 1'b1;
        tx_data_i = 8'h00;
        forever begin
            @(negedge sclk);
            rd_seen = fifo_rd_o;
            if (fifo_rd_o && empty_i) rd_empty_viol++;
            @(posedge sclk);
            #1;
            if (rd_seen && fifo_q.size() > 0) begin
                nreads++;
                tx_data_i = fifo_q.pop_front();
            end else begin
                tx_data_i = 8'($urandom);
            end
            empty_i = (fifo_q.size() == 0);
        end
    end

    // Behavioural receiver: samples msci at every msck rising edge while msen is high.
    always @(negedge sclk) begin
        if (rstn && p_rstn) begin
            if (((msen !== p_msen) || (msci !== p_msci)) && !(p_msck && !msck)) edge_viol++;
            if (msck && !p_msck) begin
                if (msen) begin
                    if (gap > 0) gaps_q.push_back(gap);
                    gap = 0;
                    run++;
                    rx_sh = {rx_sh[6:0], msci};
                    rx_bits++;
                    if (rx_bits == 8) begin
                        rx_q.push_back(rx_sh);
                        rx_bits = 0;
                    end
                end else begin
                    if (run > 0) runs_q.push_back(run);
                    run = 0;
                    rx_bits = 0;
                    gap++;
                end
            end
        end else begin
            run = 0;
            rx_bits = 0;
            gap = 0;
        end
        p_msck = msck;
        p_msci = msci;
        p_msen = msen;
        p_rstn = rstn;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (!busy_o && n < 40) begin tick(1); n++; end
        check({tag, "_busy_start"}, 32'(busy_o), 32'd1);
        n = 0;
        while (busy_o && n < 4000) begin tick(1); n++; end
        check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic measure_half(output int len);
        logic lvl;
        int   n;
        lvl = msck;
        n   = 0;
        while (msck === lvl && n < 200) begin tick(1); n++; end
        lvl = msck;
        len = 0;
        while (msck === lvl && len < 200) begin tick(1); len++; end
    endtask

    initial begin
        int n, hp, nb;
        rstn      = 1'b0;
        clk_div_r = 8'd1;
        tick(3);

        check("rst_msck", 32'(msck), 32'd0);
        check("rst_msci", 32'(msci), 32'd0);
        check("rst_msen", 32'(msen), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));

        // First rising edge arrives clk_div_r+1 sclk cycles after release.
        @(negedge sclk);
        rstn = 1'b1;
        n = 0;
        do begin
            @(posedge sclk);
            #1;
            n++;
        end while (!msck && n < 50);
        check("first_rise", 32'(n), 32'(clk_div_r) + 32'd1);

        // Single byte 0xA5 with clk_div_r=1.
        measure_half(hp);
        check("a5_half_period", 32'(hp), 32'd2);
        nreads = 0;
        runs_q.delete();
        push(8'hA5);
        wait_frame("a5");
        check("a5_reads", 32'(nreads), 32'd1);
        check("a5_runs", 32'(runs_q.size()), 32'd1);
        if (runs_q.size() > 0) check("a5_msen_edges", 32'(runs_q[0]), 32'd8);
        check_rx("a5");

        // Three bytes streamed at sclk/2.
        clk_div_r = 8'd0;
        nreads = 0;
        runs_q.delete();
        push(8'h3C);
        push(8'hFF);
        push(8'h00);
        wait_frame("b2b");
        check("b2b_reads", 32'(nreads), 32'd3);
        check("b2b_runs", 32'(runs_q.size()), 32'd1);
        if (runs_q.size() > 0) check("b2b_msen_edges", 32'(runs_q[0]), 32'd24);
        check_rx("b2b");

        // Random dividers and burst lengths: a preloaded burst is one gapless frame.
        for (int it = 0; it < 5; it++) begin
            clk_div_r = 8'($urandom_range(0, 3));
            nb = $urandom_range(1, 4);
            nreads = 0;
            runs_q.delete();
            for (int k = 0; k < nb; k++) push(8'($urandom));
            wait_frame("rnd");
            check("rnd_reads", 32'(nreads), 32'(nb));
            check("rnd_runs", 32'(runs_q.size()), 32'd1);
            if (runs_q.size() > 0) check("rnd_msen_edges", 32'(runs_q[0]), 32'(8 * nb));
            check_rx("rnd");
        end

        // Second byte arrives while the first frame is in its tail.
        clk_div_r = 8'd1;
        nreads = 0;
        push(8'h5C);
        n = 0;
        while (!msen && n < 100) begin tick(1); n++; end
        n = 0;
        while (msen && n < 200) begin tick(1); n++; end
        check("two_frame_first_end", 32'(msen), 32'd0);
        gaps_q.delete();
        push(8'hC3);
        n = 0;
        while (rx_q.size() < 2 && n < 1000) begin tick(1); n++; end
        n = 0;
        while (busy_o && n < 200) begin tick(1); n++; end
        check("two_frame_reads", 32'(nreads), 32'd2);
        check("two_frame_gaps", 32'(gaps_q.size()), 32'd1);
        if (gaps_q.size() > 0) check("two_frame_gap_min", 32'(gaps_q[0] >= TAIL_EDGES_DEF), 32'd1);
        check_rx("two_frame");

        // Reset in the middle of 0x81.
        push(8'h81);
        n = 0;
        while (rx_bits < 5 && n < 500) begin tick(1); n++; end
        check("mid_rst_bits", 32'(rx_bits), 32'd5);
        @(posedge sclk);
        #2;
        rstn = 1'b0;
        fifo_q.delete();
        #1;
        check("mid_rst_msck", 32'(msck), 32'd0);
        check("mid_rst_msci", 32'(msci), 32'd0);
        check("mid_rst_msen", 32'(msen), 32'd0);
        check("mid_rst_fifo_rd", 32'(fifo_rd_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        tick(3);
        @(negedge sclk);
        rstn = 1'b1;
        nreads = 0;
        tick(40);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_reads", 32'(nreads), 32'd0);
        rx_q.delete();
        exp_q.delete();
        runs_q.delete();

        // Divider change mid-frame takes effect only back in IDLE.
        clk_div_r = 8'd3;
        push(8'h5A);
        n = 0;
        while (!busy_o && n < 40) begin tick(1); n++; end
        clk_div_r = 8'd0;
        for (int k = 0; k < 3; k++) begin
            measure_half(hp);
            check("div_hold_half", 32'(hp), 32'd4);
        end
        n = 0;
        while (busy_o && n < 1000) begin tick(1); n++; end
        check("div_frame_end", 32'(busy_o), 32'd0);
        tick(1);
        measure_half(hp);
        check("div_idle_half", 32'(hp), 32'd1);
        check_rx("div_change");

        check("msen_msci_only_on_fall", 32'(edge_viol), 32'd0);
        check("read_while_empty", 32'(rd_empty_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
